// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bundle between the VGA timing generator and its
//               pixel source / connector logic.
// Revision    : 1.0
// ============================================================================
interface vga_timing_gen_if;
    logic       pll_locked;
    logic       running;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pll_locked,
        output running, hsync, vsync, de, pix_x, pix_y, line_start, frame_start
    );

    modport slave (
        output pll_locked,
        input  running, hsync, vsync, de, pix_x, pix_y, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 VGA raster timing, gated on a stable PLL lock.
// Revision    : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOCK_WAIT = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vga_timing_gen_if.master vga
);

    localparam int              c_LW          = $clog2(LOCK_WAIT + 1);
    localparam logic [c_LW-1:0] c_LOCK_LAST   = c_LW'(LOCK_WAIT - 1);
    localparam logic [9:0]      c_H_ACT       = 10'(H_ACTIVE);
    localparam logic [9:0]      c_H_LAST      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]      c_HS_START    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]      c_HS_END      = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]      c_V_ACT       = 10'(V_ACTIVE);
    localparam logic [9:0]      c_V_LAST      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]      c_VS_START    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]      c_VS_END      = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [0:0] {
        ST_WAIT_LOCK = 1'b0,
        ST_RUN       = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_LW-1:0] r_lock_cnt;
    logic            r_running;
    logic [9:0]      r_h;
    logic [9:0]      r_v;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [9:0]      r_pix_x;
    logic [9:0]      r_pix_y;
    logic            r_line_start;
    logic            r_frame_start;

    logic w_de;
    logic w_h_last;
    logic w_v_last;

    assign w_de     = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_h_last = (r_h == c_H_LAST);
    assign w_v_last = (r_v == c_V_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_WAIT_LOCK;
            r_lock_cnt <= '0;
            r_running  <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (!vga.pll_locked) begin
                        r_lock_cnt <= '0;
                    end else if (r_lock_cnt == c_LOCK_LAST) begin
                        r_state    <= ST_RUN;
                        r_lock_cnt <= '0;
                        r_running  <= 1'b1;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!vga.pll_locked) begin
                        r_state    <= ST_WAIT_LOCK;
                        r_lock_cnt <= '0;
                        r_running  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_WAIT_LOCK;
                    r_lock_cnt <= '0;
                    r_running  <= 1'b0;
                end
            endcase
        end
    end

    // Counters sit at (0,0) whenever the raster is not advancing, so every
    // restart after a lock loss begins a fresh frame.
    always_ff @(posedge clk) begin
        if (!rst || (r_state != ST_RUN) || !vga.pll_locked) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || (r_state != ST_RUN)) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= ((r_h >= c_HS_START) && (r_h < c_HS_END)) ? HS_POL : ~HS_POL;
            r_vsync       <= ((r_v >= c_VS_START) && (r_v < c_VS_END)) ? VS_POL : ~VS_POL;
            r_de          <= w_de;
            r_pix_x       <= w_de ? r_h : 10'd0;
            r_pix_y       <= w_de ? r_v : 10'd0;
            r_line_start  <= (r_h == 10'd0);
            r_frame_start <= (r_h == 10'd0) && (r_v == 10'd0);
        end
    end

    assign vga.running     = r_running;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.de          = r_de;
    assign vga.pix_x       = r_pix_x;
    assign vga.pix_y       = r_pix_y;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen (default and reduced raster).
// Revision    : 1.0
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic locked = 1'b0;
    int   edge_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    vga_timing_gen_if if_full ();
    vga_timing_gen_if if_small ();
    assign if_full.pll_locked  = locked;
    assign if_small.pll_locked = locked;

    vga_timing_gen dut_full (
        .clk (clk),
        .rst (rst),
        .vga (if_full)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_WAIT(16)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .vga (if_small)
    );

    typedef struct {
        int          cyc;
        logic [25:0] exp_full;
        logic [25:0] exp_small;
    } item_t;

    item_t q[$];

    // Reference model: raster position is simply the number of cycles the
    // raster has been running since its last (re)start.
    bit m_run = 1'b0;
    int m_t   = 0;
    int m_lk  = 0;

    function automatic logic [25:0] model_out(bit active, int t, bit run_next,
                                              int ha, int hf, int hs, int hb,
                                              int va, int vf, int vs, int vb,
                                              bit hp, bit vp);
        int h, v;
        bit de, hsa, vsa;
        if (!active) return {run_next, ~hp, ~vp, 3'b000, 10'd0, 10'd0};
        h   = t % (ha + hf + hs + hb);
        v   = (t / (ha + hf + hs + hb)) % (va + vf + vs + vb);
        de  = (h < ha) && (v < va);
        hsa = (h >= ha + hf) && (h < ha + hf + hs);
        vsa = (v >= va + vf) && (v < va + vf + vs);
        return {run_next, hsa ? hp : ~hp, vsa ? vp : ~vp, de, (h == 0), (h == 0 && v == 0),
                de ? 10'(h) : 10'd0, de ? 10'(v) : 10'd0};
    endfunction

    task automatic drive(input bit r, input bit l);
        item_t it;
        bit    active;
        @(posedge clk);
        #1;
        rst    = r;
        locked = l;
        active = r && m_run;
        if (!r) begin
            m_run = 1'b0;
            m_lk  = 0;
        end else if (m_run) begin
            if (!l) begin
                m_run = 1'b0;
                m_lk  = 0;
            end
        end else if (l) begin
            m_lk++;
            if (m_lk == 16) begin
                m_run = 1'b1;
                m_lk  = 0;
            end
        end else begin
            m_lk = 0;
        end
        it.cyc       = edge_cnt + 1;
        it.exp_full  = model_out(active, m_t, m_run, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        it.exp_small = model_out(active, m_t, m_run, 8, 2, 3, 4, 5, 2, 2, 3, 1'b1, 1'b1);
        q.push_back(it);
        m_t = (active && l) ? m_t + 1 : 0;
    endtask

    always @(negedge clk) begin
        item_t       it;
        logic [25:0] act_full, act_small;
        if (q.size() > 0 && q[0].cyc == edge_cnt) begin
            it = q.pop_front();
            act_full = {if_full.running, if_full.hsync, if_full.vsync, if_full.de,
                        if_full.line_start, if_full.frame_start, if_full.pix_x, if_full.pix_y};
            act_small = {if_small.running, if_small.hsync, if_small.vsync, if_small.de,
                         if_small.line_start, if_small.frame_start, if_small.pix_x, if_small.pix_y};
            checks += 2;
            if (act_full !== it.exp_full) begin
                failures++;
                $display("FAIL full_outputs cyc=%0d got=%h expected=%h", it.cyc, act_full, it.exp_full);
            end
            if (act_small !== it.exp_small) begin
                failures++;
                $display("FAIL small_outputs cyc=%0d got=%h expected=%h", it.cyc, act_small, it.exp_small);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) drive(1'b0, 1'b1);          // reset held with lock present
        repeat (40) drive(1'b1, 1'b1);         // lock qualification, raster start
        repeat (10) drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);                     // single-cycle lock dip
        repeat (20) drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        repeat (16 + 20 * 800 + 300) drive(1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0);          // drop at line 20, pixel 300
        repeat (3000) drive(1'b1, 1'b1);
        repeat (12) begin
            int len;
            len = $urandom_range(20, 1200);
            repeat (len) drive(1'b1, 1'b1);
            repeat ($urandom_range(1, 3)) drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
        end
        repeat (3) drive(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
